ricker_window_gen: RTL and testbench

- Streaming 3x3 window generator placed directly upstream of the Ricker-wavelet kernel.
- Accepts a raster-order 8-bit pixel stream with a valid/ready handshake.
- Buffers the two previous image rows and emits one packed 72-bit 3x3 neighbourhood for every interior pixel, in the exact byte order the kernel consumes.
- Border pixels produce no window; the output stream is (W-2)*(H-2) windows per frame.

---
 rtl/ricker_pkg.sv | 21 ++
 rtl/ricker_line_buffer.sv | 23 ++
 rtl/ricker_window_gen.sv | 126 ++++++++++++
 tb/tb_ricker_window_gen.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ricker_pkg.sv
// Shared constants and types for the Ricker-wavelet front end.
// A window is nine pixels: row-major, oldest row first.
package ricker_pkg;

  localparam int PIX_W    = 8;
  localparam int WIN_N    = 9;
  localparam int WIN_BITS = WIN_N * PIX_W;

  localparam int WIN_TL = 0;
  localparam int WIN_TM = 1;
  localparam int WIN_TR = 2;
  localparam int WIN_ML = 3;
  localparam int WIN_C  = 4;
  localparam int WIN_MR = 5;
  localparam int WIN_BL = 6;
  localparam int WIN_BM = 7;
  localparam int WIN_BR = 8;

  typedef logic [WIN_N-1:0][PIX_W-1:0] window_t;

endpackage

// File: rtl/ricker_line_buffer.sv
// One image row of storage: async read, write on the clock,
// so a read and write to the same address returns the old data.
module ricker_line_buffer #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  assign rdata = mem[addr];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

endmodule

// File: rtl/ricker_window_gen.sv
// Streaming 3x3 neighbourhood generator feeding the Ricker kernel.
// Emits one window per interior pixel, one cycle after its transfer.
module ricker_window_gen
  import ricker_pkg::*;
#(
  parameter int IMG_WIDTH  = 64,
  parameter int IMG_HEIGHT = 64,
  parameter int PIX_W      = ricker_pkg::PIX_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PIX_W-1:0]   in_pixel,
  input  logic               in_sof,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [9*PIX_W-1:0] out_window,
  output logic               out_last
);

  localparam int XW = $clog2(IMG_WIDTH);
  localparam int YW = $clog2(IMG_HEIGHT);
  localparam logic [XW-1:0] X_END = XW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0] Y_END = YW'(IMG_HEIGHT - 1);

  logic [XW-1:0] x_q, cx, x_n;
  logic [YW-1:0] y_q, cy, y_n;
  logic          xfer, fire, at_end;

  logic [PIX_W-1:0] lb0_rd, lb1_rd;
  logic [PIX_W-1:0] top_q [3];
  logic [PIX_W-1:0] mid_q [3];
  logic [PIX_W-1:0] bot_q [3];

  logic [WIN_N-1:0][PIX_W-1:0] win;

  assign in_ready = !out_valid || out_ready;
  assign xfer     = in_valid && in_ready;

  // start-of-frame forces this pixel to (0,0)
  assign cx = in_sof ? '0 : x_q;
  assign cy = in_sof ? '0 : y_q;

  always_comb begin
    x_n = cx + 1'b1;
    y_n = cy;
    if (cx == X_END) begin
      x_n = '0;
      y_n = (cy == Y_END) ? '0 : cy + 1'b1;
    end
  end

  assign fire   = xfer && (cx >= XW'(2)) && (cy >= YW'(2));
  assign at_end = (cx == X_END) && (cy == Y_END);

  ricker_line_buffer #(
    .DEPTH (IMG_WIDTH),
    .WIDTH (PIX_W)
  ) u_lb0 (
    .clk   (clk),
    .we    (xfer),
    .addr  (cx),
    .wdata (lb1_rd),
    .rdata (lb0_rd)
  );

  ricker_line_buffer #(
    .DEPTH (IMG_WIDTH),
    .WIDTH (PIX_W)
  ) u_lb1 (
    .clk   (clk),
    .we    (xfer),
    .addr  (cx),
    .wdata (in_pixel),
    .rdata (lb1_rd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q       <= '0;
      y_q       <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        top_q[i] <= '0;
        mid_q[i] <= '0;
        bot_q[i] <= '0;
      end
    end else if (xfer) begin
      x_q       <= x_n;
      y_q       <= y_n;
      out_valid <= fire;
      out_last  <= fire && at_end;
      top_q[0]  <= top_q[1];
      top_q[1]  <= top_q[2];
      top_q[2]  <= lb0_rd;
      mid_q[0]  <= mid_q[1];
      mid_q[1]  <= mid_q[2];
      mid_q[2]  <= lb1_rd;
      bot_q[0]  <= bot_q[1];
      bot_q[1]  <= bot_q[2];
      bot_q[2]  <= in_pixel;
    end else if (out_ready) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end
  end

  // shift registers only move on transfers, so the window holds on stall
  always_comb begin
    win         = '0;
    win[WIN_TL] = top_q[0];
    win[WIN_TM] = top_q[1];
    win[WIN_TR] = top_q[2];
    win[WIN_ML] = mid_q[0];
    win[WIN_C]  = mid_q[1];
    win[WIN_MR] = mid_q[2];
    win[WIN_BL] = bot_q[0];
    win[WIN_BM] = bot_q[1];
    win[WIN_BR] = bot_q[2];
  end

  assign out_window = win;

endmodule

// File: tb/tb_ricker_window_gen.sv
// Scoreboard bench for ricker_window_gen on a 4x4 image.
// Reference model keeps the image as a 2-D array and cuts windows.
module tb_ricker_window_gen;
  import ricker_pkg::*;

  localparam int W = 4;
  localparam int H = 4;
  localparam logic [71:0] WIN_FIRST = 72'h0A0908060504020100;
  localparam logic [71:0] WIN_LAST  = 72'h0F0E0D0B0A09070605;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_pixel = '0;
  logic        in_sof = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [71:0] out_window;
  logic        out_last;

  always #5 clk = ~clk;

  ricker_window_gen #(
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H),
    .PIX_W      (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_pixel   (in_pixel),
    .in_sof     (in_sof),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_window (out_window),
    .out_last   (out_last)
  );

  typedef struct {
    logic [71:0] win;
    logic        last;
    int          cyc;
  } exp_t;

  exp_t        q[$];
  logic [71:0] wlog[$];
  logic        llog[$];
  logic [71:0] ref_log[$];
  logic [7:0]  img [H][W];
  int          mx = 0;
  int          my = 0;
  int          npush = 0;
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  bit          strict = 1'b0;
  bit          rnd_on = 1'b0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [71:0] act,
                     input logic [71:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic void model_accept(input logic [7:0] p, input bit sof);
    window_t w;
    exp_t    e;
    if (sof) begin
      mx = 0;
      my = 0;
    end
    img[my][mx] = p;
    if (mx >= 2 && my >= 2) begin
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          w[r*3+c] = img[my-2+r][mx-2+c];
      e.win  = w;
      e.last = (mx == W-1) && (my == H-1);
      e.cyc  = cyc;
      q.push_back(e);
      npush++;
    end
    mx++;
    if (mx == W) begin
      mx = 0;
      my = (my == H-1) ? 0 : my + 1;
    end
  endfunction

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      wlog.push_back(out_window);
      llog.push_back(out_last);
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_window actual=%h required=none",
                 out_window);
      end else begin
        e = q.pop_front();
        chk("window", out_window, e.win);
        chk("last", 72'(out_last), 72'(e.last));
        if (strict) chk("latency", 72'(cyc), 72'(e.cyc));
      end
    end
  end

  task automatic send(input logic [7:0] p, input bit sof, input int gap);
    bit acc;
    int n;
    in_pixel = p;
    in_sof   = sof;
    in_valid = 1'b1;
    acc = 1'b0;
    n = 0;
    while (!acc) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
      if (!acc && n > 200) begin
        checks++;
        failures++;
        $display("FAIL accept_timeout actual=stalled required=accept");
        in_valid = 1'b0;
        in_sof   = 1'b0;
        return;
      end
    end
    model_accept(p, sof);
    in_sof = 1'b0;
    if (gap > 0) begin
      in_valid = 1'b0;
      repeat (gap) @(posedge clk);
      #1;
    end
  endtask

  task automatic std_frame(input int gap);
    for (int i = 0; i < W*H; i++) send(8'(i), i == 0, gap);
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name, input int n_exp);
    int n;
    out_ready = 1'b1;
    n = 0;
    while (q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk({name, "_pending"}, 72'(q.size()), 72'd0);
    chk({name, "_count"}, 72'(wlog.size()), 72'(n_exp));
  endtask

  task automatic cmp_ref(input string name);
    for (int i = 0; i < 4; i++)
      if (i < wlog.size() && i < ref_log.size())
        chk(name, wlog[i], ref_log[i]);
  endtask

  task automatic clear_logs();
    wlog.delete();
    llog.delete();
  endtask

  initial begin
    int n;
    int base;
    int len;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 72'(out_valid), 72'd0);
    chk("rst_window", out_window, 72'd0);
    chk("rst_last", 72'(out_last), 72'd0);
    chk("rst_in_ready", 72'(in_ready), 72'd1);
    rst_n = 1'b1;

    // continuous stream
    clear_logs();
    strict = 1'b1;
    out_ready = 1'b1;
    std_frame(0);
    drain("cont", 4);
    if (wlog.size() >= 4) begin
      chk("cont_first", wlog[0], WIN_FIRST);
      chk("cont_fourth", wlog[3], WIN_LAST);
      chk("cont_last0", 72'(llog[0]), 72'd0);
      chk("cont_last3", 72'(llog[3]), 72'd1);
    end
    ref_log = wlog;

    // stall after first window
    clear_logs();
    strict = 1'b0;
    out_ready = 1'b0;
    fork
      std_frame(0);
      begin
        n = 0;
        while (!out_valid && n < 200) begin
          @(negedge clk);
          n++;
        end
        chk("stall_seen", 72'(out_valid), 72'd1);
        repeat (3) begin
          @(negedge clk);
          chk("stall_window", out_window, WIN_FIRST);
          chk("stall_in_ready", 72'(in_ready), 72'd0);
          chk("stall_valid", 72'(out_valid), 72'd1);
        end
        chk("stall_queued", 72'(q.size()), 72'd1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain("stall", 4);
    cmp_ref("stall_match");

    // two frames back to back
    clear_logs();
    strict = 1'b1;
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < W*H; i++) send(8'(i), i == 0, 0);
    in_valid = 1'b0;
    drain("b2b", 8);
    for (int i = 0; i < 8; i++)
      if (i < wlog.size()) begin
        chk("b2b_last", 72'(llog[i]), 72'(i == 3 || i == 7));
        if (i >= 4) chk("b2b_repeat", wlog[i], wlog[i-4]);
      end

    // start-of-frame in the middle of a frame
    clear_logs();
    for (int i = 0; i < 6; i++) send(8'(i), i == 0, 0);
    std_frame(0);
    drain("midsof", 4);
    cmp_ref("midsof_match");

    // reset while a window is pending
    clear_logs();
    strict = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i <= 10; i++) send(8'(i), i == 0, 0);
    in_valid = 1'b0;
    chk("pre_rst_valid", 72'(out_valid), 72'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 72'(out_valid), 72'd0);
    chk("async_rst_window", out_window, 72'd0);
    chk("async_rst_last", 72'(out_last), 72'd0);
    q.delete();
    mx = 0;
    my = 0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    clear_logs();
    strict = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < W*H; i++) send(8'(i), 1'b0, 0);
    in_valid = 1'b0;
    drain("postrst", 4);
    cmp_ref("postrst_match");

    // sparse input
    clear_logs();
    strict = 1'b0;
    std_frame(1);
    drain("sparse", 4);
    cmp_ref("sparse_match");

    // random pixels, gaps, back-pressure and truncated frames
    clear_logs();
    base = npush;
    rnd_on = 1'b1;
    fork
      begin
        for (int f = 0; f < 8; f++) begin
          len = ($urandom_range(0, 3) == 0) ?
                int'($urandom_range(1, 15)) : W*H;
          for (int i = 0; i < len; i++)
            send(8'($urandom), i == 0, int'($urandom_range(0, 2)));
        end
        in_valid = 1'b0;
        rnd_on = 1'b0;
      end
      begin
        while (rnd_on) begin
          @(posedge clk);
          #1;
          if (rnd_on) out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    drain("random", npush - base);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
